// File: rtl/freq_monitor_pkg.sv
// Shared types and constants for the frequency monitor: FSM states,
// register map, STATUS bit layout and the tolerance helper.
package freq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_LOST    = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_LAST   = 2'd1;
   localparam logic [1:0] ADDR_MIN    = 2'd2;
   localparam logic [1:0] ADDR_MAX    = 2'd3;

   localparam int STATUS_LOCKED_BIT  = 0;
   localparam int STATUS_LOSS_BIT    = 1;
   localparam int STATUS_TIMEOUT_BIT = 2;
   localparam int STATUS_STATE_LSB   = 8;

   // Product is formed in 64 bits so large ExpectedHz*ppm cannot overflow.
   function automatic logic [31:0] calc_tol_hz(input longint unsigned expected_hz,
                                               input longint unsigned tol_ppm);
      longint unsigned tol;
      tol = (expected_hz * tol_ppm) / 64'd1_000_000;
      return tol[31:0];
   endfunction

endpackage

// File: rtl/freq_monitor_watchdog.sv
// Saturating count of cycles since the last measurement strobe; emits a
// single-cycle timeout pulse when the limit is reached.
module freq_monitor_watchdog #(
   parameter int unsigned TimeoutCycles = 20000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic timeout
);

   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles);

   logic [CntW-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (cnt_q != Limit) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A strobe in the expiry cycle suppresses the event; saturation at Limit
   // keeps the pulse from repeating.
   assign timeout = !clear && (cnt_q == Limit - CntW'(1));

endmodule

// File: rtl/freq_monitor.sv
// Checks each published frequency against ExpectedHz +/- TolerancePpm, tracks
// lock with hysteresis, keeps min/max/last and exposes them over Avalon-MM.
module freq_monitor
   import freq_monitor_pkg::*;
#(
   parameter int unsigned ExpectedHz    = 106250000,
   parameter int unsigned TolerancePpm  = 200,
   parameter int unsigned LockCount     = 4,
   parameter int unsigned LossCount     = 2,
   parameter int unsigned TimeoutCycles = 20000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        freq_valid,
   input  logic [31:0] freq_hz,
   input  logic [1:0]  mm_address,
   input  logic        mm_read,
   output logic [31:0] mm_readdata,
   output logic        locked,
   output logic        alarm
);

   localparam logic [31:0] ExpectedHzL = 32'(ExpectedHz);
   localparam logic [31:0] TolHz       = calc_tol_hz(64'(ExpectedHz), 64'(TolerancePpm));
   localparam logic [31:0] LockCountL  = 32'(LockCount);
   localparam logic [31:0] LossCountL  = 32'(LossCount);

   state_e      state_q, state_d;
   logic [31:0] run_q, run_d, bad_q, bad_d;
   logic        loss_q, timeout_q, loss_set, timeout_set;
   logic [31:0] last_q, min_q, max_q;
   logic [31:0] status_word, rd_mux;
   logic        timeout, stat_clear, in_range;
   logic signed [32:0] diff;
   logic [32:0] abs_diff;

   freq_monitor_watchdog #(.TimeoutCycles(TimeoutCycles)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (freq_valid),
      .timeout (timeout)
   );

   assign diff     = $signed({1'b0, freq_hz}) - $signed({1'b0, ExpectedHzL});
   assign abs_diff = diff[32] ? 33'(-diff) : 33'(diff);
   assign in_range = (abs_diff <= {1'b0, TolHz});

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path through the block can infer a latch.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      bad_d       = bad_q;
      loss_set    = 1'b0;
      timeout_set = 1'b0;
      if (timeout) begin
         state_d     = ST_LOST;
         run_d       = '0;
         bad_d       = '0;
         timeout_set = 1'b1;
      end else if (freq_valid) begin
         unique case (state_q)
            ST_LOCKED: begin
               if (in_range) begin
                  bad_d = '0;
               end else if (bad_q + 32'd1 >= LossCountL) begin
                  state_d  = ST_LOST;
                  bad_d    = '0;
                  loss_set = 1'b1;
               end else begin
                  bad_d = bad_q + 32'd1;
               end
            end
            default: begin
               if (!in_range) begin
                  run_d = '0;
               end else if (run_q + 32'd1 >= LockCountL) begin
                  state_d = ST_LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 32'd1;
               end
            end
         endcase
      end
   end

   assign stat_clear = mm_read && (mm_address == ADDR_STATUS);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_ACQUIRE;
         run_q     <= '0;
         bad_q     <= '0;
         loss_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         bad_q     <= bad_d;
         // Set wins over a coincident read-clear.
         loss_q    <= loss_set    | (loss_q    & ~stat_clear);
         timeout_q <= timeout_set | (timeout_q & ~stat_clear);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
         min_q  <= '1;
         max_q  <= '0;
      end else begin
         if (freq_valid) last_q <= freq_hz;
         if (stat_clear) begin
            min_q <= freq_valid ? freq_hz : '1;
            max_q <= freq_valid ? freq_hz : '0;
         end else if (freq_valid) begin
            if (freq_hz < min_q) min_q <= freq_hz;
            if (freq_hz > max_q) max_q <= freq_hz;
         end
      end
   end

   assign locked = (state_q == ST_LOCKED);
   assign alarm  = loss_q | timeout_q;

   always_comb begin
      status_word                              = '0;
      status_word[STATUS_LOCKED_BIT]           = locked;
      status_word[STATUS_LOSS_BIT]             = loss_q;
      status_word[STATUS_TIMEOUT_BIT]          = timeout_q;
      status_word[STATUS_STATE_LSB +: 2]       = state_q;
   end

   always_comb begin
      rd_mux = '0;
      unique case (mm_address)
         ADDR_STATUS: rd_mux = status_word;
         ADDR_LAST:   rd_mux = last_q;
         ADDR_MIN:    rd_mux = min_q;
         ADDR_MAX:    rd_mux = max_q;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mm_readdata <= '0;
      end else if (mm_read) begin
         mm_readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_freq_monitor.sv
// Directed bench for freq_monitor; register reads are checked by a
// scoreboard monitor, lock/alarm outputs by direct checks.
module tb_freq_monitor;
   import freq_monitor_pkg::*;

   localparam logic [31:0] F_NOM    = 32'd106250000;
   localparam logic [31:0] F_IN     = 32'd106260000;
   localparam logic [31:0] F_HI_EDG = 32'd106271250;
   localparam logic [31:0] F_LO_EDG = 32'd106228750;
   localparam logic [31:0] F_HI_OUT = 32'd106271251;
   localparam logic [31:0] F_FAR    = 32'd106383400;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        freq_valid = 1'b0;
   logic [31:0] freq_hz = '0;
   logic [1:0]  mm_address = '0;
   logic        mm_read = 1'b0;
   logic [31:0] mm_readdata;
   logic        locked, alarm;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   logic [1:0]  addr_q[$];
   logic        rd_pend = 1'b0;
   logic [31:0] mon_exp;
   logic [1:0]  mon_addr;

   freq_monitor #(
      .ExpectedHz    (106250000),
      .TolerancePpm  (200),
      .LockCount     (4),
      .LossCount     (2),
      .TimeoutCycles (1000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .freq_valid  (freq_valid),
      .freq_hz     (freq_hz),
      .mm_address  (mm_address),
      .mm_read     (mm_read),
      .mm_readdata (mm_readdata),
      .locked      (locked),
      .alarm       (alarm)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: read data is valid in the cycle after mm_read.
   always @(posedge clk) rd_pend <= mm_read & ~reset;

   always @(negedge clk) begin
      if (rd_pend) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_read got 0x%08h exp none", mm_readdata);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_addr = addr_q.pop_front();
            if (mm_readdata !== mon_exp) begin
               n_err++;
               $display("FAIL read_addr%0d got 0x%08h exp 0x%08h", mon_addr, mm_readdata, mon_exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_time_limit got hang exp finish");
      $fatal(1, "time limit");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%08h exp 0x%08h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [31:0] f);
      freq_valid = 1'b1;
      freq_hz    = f;
      tick(1);
      freq_valid = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp);
      mm_read    = 1'b1;
      mm_address = a;
      exp_q.push_back(exp);
      addr_q.push_back(a);
      tick(1);
      mm_read = 1'b0;
   endtask

   task automatic rd_strobe(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] f);
      freq_valid = 1'b1;
      freq_hz    = f;
      rd(a, exp);
      freq_valid = 1'b0;
   endtask

   logic [31:0] bnd [8];

   initial begin
      bnd = '{F_HI_EDG, F_LO_EDG, F_HI_EDG, F_HI_OUT, F_LO_EDG, F_HI_EDG, F_LO_EDG, F_HI_EDG};

      // Reset state
      tick(3);
      reset = 1'b0;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_readdata", mm_readdata, 32'd0);
      rd(ADDR_LAST, 32'd0);
      rd(ADDR_MIN, 32'hFFFF_FFFF);
      rd(ADDR_MAX, 32'd0);
      rd(ADDR_STATUS, 32'h0);

      // Lock acquisition: 4 strobes 100 cycles apart
      for (int i = 0; i < 4; i++) begin
         strobe(F_IN);
         check($sformatf("lock_after_%0d", i + 1), 32'(locked), (i == 3) ? 32'd1 : 32'd0);
         tick(99);
      end
      rd(ADDR_STATUS, 32'h101);

      // Reset mid-lock with read data in flight
      rd(ADDR_LAST, F_IN);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_alarm", 32'(alarm), 32'd0);
      check("midrst_readdata", mm_readdata, 32'd0);
      rd(ADDR_STATUS, 32'h0);
      rd(ADDR_MIN, 32'hFFFF_FFFF);

      // Window boundary: 3 in, 1 just out, then 4 in
      for (int i = 0; i < 8; i++) begin
         strobe(bnd[i]);
         check($sformatf("bound_lock_%0d", i), 32'(locked), (i == 7) ? 32'd1 : 32'd0);
         tick(9);
      end
      rd(ADDR_STATUS, 32'h101);

      // Loss of lock: single outlier tolerated, two consecutive lose lock
      strobe(F_FAR);
      check("loss_single_out", 32'(locked), 32'd1);
      tick(9);
      strobe(F_NOM);
      check("loss_recover_in", 32'(locked), 32'd1);
      tick(9);
      strobe(F_FAR);
      check("loss_first_out", 32'(locked), 32'd1);
      tick(9);
      strobe(F_FAR);
      check("loss_locked", 32'(locked), 32'd0);
      check("loss_alarm", 32'(alarm), 32'd1);
      rd(ADDR_STATUS, 32'h202);
      check("loss_alarm_cleared", 32'(alarm), 32'd0);
      rd(ADDR_STATUS, 32'h200);

      // Relock from LOST, then timeout boundary
      for (int i = 0; i < 4; i++) begin
         strobe(F_NOM);
         if (i < 3) tick(9);
      end
      check("relock", 32'(locked), 32'd1);
      tick(999);
      strobe(F_NOM);                    // lands on cycle 1000 exactly
      check("to_edge_locked", 32'(locked), 32'd1);
      check("to_edge_alarm", 32'(alarm), 32'd0);
      tick(999);
      check("to_pending_locked", 32'(locked), 32'd1);
      tick(1);
      check("to_locked", 32'(locked), 32'd0);
      check("to_alarm", 32'(alarm), 32'd1);
      rd(ADDR_STATUS, 32'h204);
      tick(2500);
      check("to_saturate_alarm", 32'(alarm), 32'd0);
      rd(ADDR_STATUS, 32'h200);

      // Statistics and read-clear
      strobe(32'd106250000);
      tick(9);
      strobe(32'd106200000);
      tick(9);
      strobe(32'd106300000);
      tick(9);
      rd(ADDR_LAST, 32'd106300000);
      rd(ADDR_MIN, 32'd106200000);
      rd(ADDR_MAX, 32'd106300000);
      rd(ADDR_STATUS, 32'h200);
      rd(ADDR_MIN, 32'hFFFF_FFFF);
      rd(ADDR_MAX, 32'd0);
      rd(ADDR_LAST, 32'd106300000);

      // Strobe coinciding with the clearing read seeds MIN/MAX
      rd_strobe(ADDR_STATUS, 32'h200, 32'd106240000);
      rd(ADDR_MIN, 32'd106240000);
      rd(ADDR_MAX, 32'd106240000);

      // Loss event coinciding with the clearing read: set wins
      for (int i = 0; i < 3; i++) begin
         tick(9);
         strobe(32'd106240000);
      end
      check("coin_relock", 32'(locked), 32'd1);
      tick(9);
      strobe(F_FAR);
      tick(9);
      rd_strobe(ADDR_STATUS, 32'h101, F_FAR);
      check("coin_locked", 32'(locked), 32'd0);
      check("coin_alarm", 32'(alarm), 32'd1);
      rd(ADDR_STATUS, 32'h202);
      rd(ADDR_STATUS, 32'h200);
      check("coin_alarm_cleared", 32'(alarm), 32'd0);

      tick(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
